// File: rtl/scramble_seq_pkg.sv
// Shared constants for the scrambler job sequencer.
// Holds the FSM state encoding, default geometry and the start-acknowledge timeout.
package scramble_seq_pkg;

   localparam int DEPTH_DEF   = 32;
   localparam int AW_DEF      = 5;
   localparam int DW_DEF      = 8;
   localparam int ACK_TIMEOUT = 4;

   localparam logic [2:0] ST_RESYNC = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_KICK   = 3'd2;
   localparam logic [2:0] ST_ACK    = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;
   localparam logic [2:0] ST_DRAIN  = 3'd5;

   typedef enum logic [2:0] {
      S_RESYNC = ST_RESYNC,
      S_LOAD   = ST_LOAD,
      S_KICK   = ST_KICK,
      S_ACK    = ST_ACK,
      S_RUN    = ST_RUN,
      S_DRAIN  = ST_DRAIN
   } seq_state_t;

endpackage

// File: rtl/seq_out_stage.sv
// Output register of the job sequencer: pulls regfile bytes while draining, tracks the last flag.
// Latency: one cycle from a read-address cycle to out_valid; sustains one byte per cycle.
// Backpressure: out_ready=0 freezes out_data/out_last and stops further regfile reads.
module seq_out_stage
#(
   parameter int DW = 8
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          drain,
   input  logic [DW-1:0] rd_data,
   input  logic          rd_last,
   output logic          ld_take,
   output logic          last_hs,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   input  logic          out_ready
);

   // Set once the final byte of the job sits in the register; no more reads after that.
   logic ld_done;

   assign ld_take = drain && !ld_done && (!out_valid || out_ready);
   assign last_hs = out_valid && out_ready && out_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         ld_done   <= 1'b0;
      end else begin
         if (ld_take) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_last  <= rd_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (last_hs)
            ld_done <= 1'b0;
         else if (ld_take && rd_last)
            ld_done <= 1'b1;
      end
   end

endmodule

// File: rtl/scramble_job_seq.sv
// Job sequencer: loads 1..DEPTH bytes into the scrambler regfile, launches it, streams results.
// Latency: write in the handshake cycle, start 1 cycle after close, first output 1 cycle into DRAIN.
// Backpressure: in_ready only in LOAD; output stalls hold data. Optional bypass port: SEQ_BYPASS_EN.
module scramble_job_seq
   import scramble_seq_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          in_ready,
`ifdef SEQ_BYPASS_EN
   input  logic          bypass,
`endif
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   input  logic          out_ready,
   output logic          scr_start,
   output logic [AW-1:0] scr_len_1,
   input  logic          scr_busy,
   output logic [AW-1:0] usr_r_addr,
   output logic [AW-1:0] usr_w_addr,
   output logic [DW-1:0] usr_din,
   output logic          usr_wr_en,
   input  logic [DW-1:0] scr_dout,
   output logic          job_done,
   output logic          err_trunc,
   output logic          err_nostart
);

   localparam int ACW = $clog2(ACK_TIMEOUT);

   seq_state_t     state;
   logic [AW-1:0]  w_ptr;
   logic [AW-1:0]  r_ptr;
   logic [ACW-1:0] ack_cnt;

   logic in_hs;
   logic at_end;
   logic close;
   logic skip_scr;
   logic drain;
   logic ld_take;
   logic last_hs;

   assign in_hs  = in_valid && in_ready;
   assign at_end = (w_ptr == AW'(DEPTH - 1));
   assign close  = in_hs && (in_last || at_end);
   assign drain  = (state == S_DRAIN);

   // w_ptr still holds the closing byte's index here, so zero means a one-byte job.
`ifdef SEQ_BYPASS_EN
   assign skip_scr = (w_ptr == '0) || bypass;
`else
   assign skip_scr = (w_ptr == '0);
`endif

   assign usr_wr_en  = in_hs;
   assign usr_w_addr = w_ptr;
   assign usr_din    = in_hs ? in_data : '0;
   assign usr_r_addr = r_ptr;

   seq_out_stage #(.DW(DW)) u_out (
      .clk       (clk),
      .rst       (rst),
      .drain     (drain),
      .rd_data   (scr_dout),
      .rd_last   (r_ptr == scr_len_1),
      .ld_take   (ld_take),
      .last_hs   (last_hs),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_RESYNC;
         w_ptr       <= '0;
         r_ptr       <= '0;
         ack_cnt     <= '0;
         scr_len_1   <= '0;
         in_ready    <= 1'b0;
         scr_start   <= 1'b0;
         job_done    <= 1'b0;
         err_trunc   <= 1'b0;
         err_nostart <= 1'b0;
      end else begin
         scr_start <= 1'b0;
         job_done  <= 1'b0;
         case (state)
            // A reset can land mid-scramble; the regfile is not ours until busy drops.
            S_RESYNC: begin
               if (!scr_busy) begin
                  state    <= S_LOAD;
                  in_ready <= 1'b1;
               end
            end
            S_LOAD: begin
               if (close) begin
                  w_ptr     <= '0;
                  scr_len_1 <= w_ptr;
                  in_ready  <= 1'b0;
                  if (!in_last)
                     err_trunc <= 1'b1;
                  if (skip_scr) begin
                     state <= S_DRAIN;
                  end else begin
                     state     <= S_KICK;
                     scr_start <= 1'b1;
                  end
               end else if (in_hs) begin
                  w_ptr <= w_ptr + 1'b1;
               end
            end
            S_KICK: begin
               state   <= S_ACK;
               ack_cnt <= '0;
            end
            S_ACK: begin
               if (scr_busy) begin
                  state <= S_RUN;
               end else if (ack_cnt == ACW'(ACK_TIMEOUT - 1)) begin
                  state       <= S_DRAIN;
                  err_nostart <= 1'b1;
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (!scr_busy)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (ld_take)
                  r_ptr <= r_ptr + 1'b1;
               if (last_hs) begin
                  r_ptr    <= '0;
                  job_done <= 1'b1;
                  in_ready <= 1'b1;
                  state    <= S_LOAD;
               end
            end
            default: state <= S_RESYNC;
         endcase
      end
   end

endmodule

// File: doc/scramble_job_seq.md
# scramble_job_seq

Job sequencer for the 32-entry byte scrambler. It accepts a packet of 1–32 bytes over a valid/ready stream and writes it into the scrambler's register file through the user port. It then launches the scramble, waits for completion, and streams the permuted bytes out over a second valid/ready stream. It sits between the system byte streams and the scrambler top: it drives `start`, `len_1` and the `usr_*` regfile port, and it observes `busy` and `dout`.

## Interface
- `DEPTH`, 32: regfile entries; maximum job length.
- `AW`, 5: address width, equal to log2(DEPTH).
- `DW`, 8: data width.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  DW  input byte.
- `in_last`  in  1  final byte of the job.
- `in_ready`  out  1  sequencer accepts a byte.
- `out_valid`  out  1  output byte valid (registered).
- `out_data`  out  DW  output byte (registered).
- `out_last`  out  1  final output byte (registered).
- `out_ready`  in  1  downstream accepts.
- `scr_start`  out  1  one-cycle scramble launch.
- `scr_len_1`  out  AW  job length minus 1; held stable from the start pulse until the job finishes.
- `scr_busy`  in  1  scrambler running.
- `usr_r_addr`, `usr_w_addr`  out  AW  regfile user addresses.
- `usr_din`  out  DW  regfile write data.
- `usr_wr_en`  out  1  regfile write strobe.
- `scr_dout`  in  DW  regfile read data; asynchronous read of `usr_r_addr`.
- `job_done`  out  1  one-cycle pulse after the last output handshake.
- `err_trunc`  out  1  sticky: a job was truncated at DEPTH bytes.
- `err_nostart`  out  1  sticky: the scrambler never raised busy.

## Operation
- States: RESYNC, LOAD, KICK, ACK, RUN, DRAIN.
- Reset: state RESYNC, `w_ptr`=`r_ptr`=0, `scr_len_1`=0. All outputs are 0 and both sticky flags are cleared.
- RESYNC:
  - Waits for `scr_busy`=0, because reset may arrive mid-scramble.
  - Then goes to LOAD.
  - `in_ready`=0 throughout.
- LOAD:
  - `in_ready`=1.
  - On each handshake: `usr_wr_en`=1, `usr_w_addr`=`w_ptr`, `usr_din`=`in_data`, then `w_ptr`++.
  - The job closes on a handshake with `in_last`=1, or on the handshake at `w_ptr`=DEPTH-1. Closing at DEPTH-1 without `in_last` sets `err_trunc`, and the remaining input bytes form the next job.
  - On close: `scr_len_1` is latched to `w_ptr` (the value before increment) and `w_ptr` is cleared.
  - If `scr_len_1`=0, go to DRAIN (single-byte jobs skip scrambling). Otherwise go to KICK.
- KICK: `scr_start`=1 for exactly one cycle, then go to ACK.
- ACK:
  - Waits up to 4 cycles for `scr_busy`=1; when seen, go to RUN.
  - On timeout: set `err_nostart` and go to DRAIN, outputting the unscrambled bytes.
- RUN: waits for `scr_busy`=0, then goes to DRAIN. `usr_wr_en` is 0.
- DRAIN:
  - `usr_r_addr`=`r_ptr`.
  - The output register loads `scr_dout` when `out_valid`=0 or `out_ready`=1, and `r_ptr`++.
  - `out_last`=1 when the loaded index equals `scr_len_1`.
  - After the handshake with `out_last`: pulse `job_done`, clear `r_ptr`, go to LOAD.
- `usr_wr_en` is asserted only in LOAD.

## Timing
- The input write happens in the same cycle as the handshake.
- KICK follows the closing handshake by 1 cycle.
- The first `out_valid` appears 1 cycle after entering DRAIN.
- With `out_ready` held at 1, the output sustains 1 byte/cycle. With `out_ready`=0, `out_data` and `out_last` hold stable.
- `job_done` is asserted in the cycle after the final output handshake. `in_ready` rises in that same cycle.
- If `rst` is asserted in any state, the block is in RESYNC on the next edge and partial jobs are discarded.

## Configuration
- `SEQ_BYPASS_EN` defined:
  - Adds input port `bypass` (1 bit), sampled at job close.
  - If the sampled value is 1, LOAD goes directly to DRAIN and the bytes are output in order.
- `SEQ_BYPASS_EN` undefined: the `bypass` port is absent and every job with `scr_len_1`>0 is scrambled.

## Structure
- Package `scramble_seq_pkg` holds:
  - the state encoding (3-bit localparams);
  - the default DEPTH, AW and DW;
  - the ACK timeout constant (4).
- Sub-module `seq_out_stage` contains the output register, `out_valid`/`out_ready` logic and last-flag tracking. The FSM and pointers stay in the top module.

## Test plan
- Job of 10 bytes (0x00–0x09), `out_ready`=1 → writes go to addresses 0–9, `scr_len_1`=9, and one `scr_start` pulse is issued. The output is 10 bytes with `out_last` on the 10th, the output multiset equals the input, and `job_done` pulses once.
- Single byte 0xA5 with `in_last` → no `scr_start`; output is 0xA5 with `out_last`=1.
- 33 bytes with no `in_last` → first job has `scr_len_1`=31 and `err_trunc`=1; byte 33 starts the next job.
- Scrambler model that never raises busy → `err_nostart`=1 after 4 ACK cycles, and the bytes are output in order.
- `out_ready` toggled 1/0 every cycle during DRAIN → no byte is lost or duplicated, and `out_data` is stable while stalled.
- `rst` pulsed while `scr_busy`=1 → `in_ready` stays 0 until `scr_busy` falls, then the next job completes normally.
